ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter WAIT_W, default 2: write-strobe width in CLK cycles (legal 1..15).
REQ-002 Parameter WAIT_R, default 2: read-strobe width in CLK cycles before data capture (legal 1..15).
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 REQ  in  1  transaction request, sampled only in IDLE.
REQ-006 WR  in  1  1=write, 0=read; sampled with REQ.
REQ-007 ADDR  in  4  word address; sampled with REQ.
REQ-008 WDATA  in  8  write data; sampled with REQ.
REQ-009 BUSY  out  1  high while a transaction is in progress.
REQ-010 ACK  out  1  one-cycle completion pulse.
REQ-011 RDATA  out  8  last read result, registered.
REQ-012 RAM_ADDR  out  4  to the RAM model's addr.
REQ-013 RAM_DATA  inout  8  to the RAM model's data; tristated when not driving.
REQ-014 RAM_CEB, RAM_WEB, RAM_OEB  out  1 each  active-low chip, write and output enables.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, WACC, RACC and DONE.
REQ-016 IDLE with REQ=1 at a rising edge SHALL latch WR, ADDR and WDATA and move to SETUP; REQ=0 SHALL stay in IDLE.
REQ-017 SETUP SHALL last 1 cycle with CEB=0, WEB=1, OEB=1 and RAM_ADDR stable, then go to WACC (write) or RACC (read).
REQ-018 WACC SHALL last exactly WAIT_W cycles with CEB=0, WEB=0, OEB=1, then go to DONE.
REQ-019 RACC SHALL last exactly WAIT_R cycles with CEB=0, WEB=1, OEB=0, then go to DONE.
REQ-020 RDATA SHALL load RAM_DATA on the edge ending the last RACC cycle; RDATA SHALL be unchanged at all other times, including by writes.
REQ-021 DONE SHALL last 1 cycle with CEB=WEB=OEB=1 and ACK=1, then go to IDLE.
REQ-022 RAM_DATA SHALL be driven with the latched WDATA in SETUP, WACC and DONE of a write only, and SHALL be high-Z otherwise.
REQ-023 RAM_OEB=0 and RAM_DATA driven SHALL never coincide.
REQ-024 WEB=0 and OEB=0 SHALL never coincide.
REQ-025 RAM_ADDR SHALL hold the latched address from SETUP until the next acceptance.
REQ-026 BUSY SHALL be 1 in SETUP, WACC, RACC and DONE, and 0 in IDLE.
REQ-027 REQ SHALL be ignored while BUSY=1; there is no queueing.
REQ-028 Latency: if acceptance is at edge E0, ACK SHALL be high in the cycle after edge E0+N+1, where N=WAIT_W or WAIT_R.
REQ-029 Minimum request spacing SHALL be N+3 cycles.
REQ-030 The wait counter SHALL be 4 bits, load N-1 on entering WACC or RACC, and leave on reaching 0.
REQ-031 Parameter value 0 SHALL behave as 1.
REQ-032 All strobe outputs and the RAM_DATA enable SHALL come directly from flops; none SHALL come from combinational decode of inputs.

Reset
REQ-033 RST=1 at a rising edge SHALL force IDLE from any state, including mid-WACC or mid-RACC.
REQ-034 On that edge the outputs SHALL become: CEB=WEB=OEB=1, RAM_DATA high-Z, BUSY=0, ACK=0, RAM_ADDR=0, RDATA=8'h00, counter=0.
REQ-035 A write cut short by reset SHALL leave the target RAM word undefined; no ACK SHALL be issued for it.
REQ-036 RST SHALL take priority over REQ in the same cycle.

Structure
REQ-037 Package ram_pkg SHALL hold ADDR_W=4, DATA_W=8 and the FSM state encodings, and SHALL be shared with any other RAM-side blocks.
REQ-038 A single sub-module, ram_ctrl_wcnt (loadable 4-bit down-counter with zero flag), SHALL be instantiated; all other logic SHALL be flat.

Verification
REQ-039 The bench SHALL pair ram_ctrl with the team RAM simulation model at a 10 ns CLK, with WAIT_W=WAIT_R=2.
REQ-040 Write: REQ,WR=1,ADDR=3,WDATA=A5 -> WEB low exactly 2 cycles; ACK in cycle E0+3 after the acceptance edge; mem[3]=A5.
REQ-041 Read-back: REQ,WR=0,ADDR=3 -> OEB low exactly 2 cycles; RDATA=A5 in the same cycle as ACK; RDATA still A5 after a later write of 3C to ADDR 7.
REQ-042 Busy rejection: a second REQ (ADDR=5) pulsed during WACC -> no second transaction and one ACK only; a request accepted 5 cycles after the first then completes normally.
REQ-043 Reset mid-write: RST in the 1st WACC cycle -> next edge gives CEB=WEB=1, bus high-Z, BUSY=0, no ACK; a following read of ADDR 0 completes normally.
REQ-044 Continuous checker for all runs: no cycle has WEB=0 with OEB=0, and no cycle has OEB=0 with RAM_DATA driven; also run with WAIT_R=1 and WAIT_R=0 and check both give a 1-cycle read strobe.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the asynchronous SRAM controller and other RAM-side blocks.
// Holds bus widths, the controller FSM encoding and the wait-count load helper.
package ram_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WACC  = 3'd2,
    ST_RACC  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Strobe width N becomes a counter load of N-1; zero is treated as one, oversize clamps to 15.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned n);
    if (n <= 32'd1) begin
      wait_load = {CNT_W{1'b0}};
    end else if (n > 32'd15) begin
      wait_load = 4'd14;
    end else begin
      wait_load = CNT_W'(n - 32'd1);
    end
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// Host-side request/response bus of the SRAM controller.
interface ram_ctrl_if;
  import ram_pkg::*;

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, addr, wdata,
    input  busy, ack, rdata
  );

  modport slave (
    input  req, wr, addr, wdata,
    output busy, ack, rdata
  );

endinterface

// File: rtl/ram_ctrl_wcnt.sv
// Loadable down-counter timing the write/read strobe phases; zero flag marks the last cycle.
module ram_ctrl_wcnt
  import ram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && !zero) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ram_ctrl.sv
// Asynchronous SRAM controller: one request at a time, setup / strobe / done sequencing,
// with every strobe and the data-bus enable taken straight from flops.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned WAIT_W = 2,
  parameter int unsigned WAIT_R = 2
) (
  input  logic              clk,
  input  logic              rst,
  ram_ctrl_if.slave         host,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ceb,
  output logic              ram_web,
  output logic              ram_oeb
);

  localparam logic [CNT_W-1:0] LOAD_W = wait_load(WAIT_W);
  localparam logic [CNT_W-1:0] LOAD_R = wait_load(WAIT_R);

  state_t            state_r;
  state_t            next_s;
  logic              accept_s;
  logic              wr_next_s;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic [CNT_W-1:0]  cnt_val_s;
  logic              cnt_zero_s;

  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              ceb_r;
  logic              web_r;
  logic              oeb_r;
  logic              data_oe_r;
  logic              busy_r;
  logic              ack_r;

  ram_ctrl_wcnt u_wcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // Next-state decode and wait-counter control.
  always_comb begin
    next_s     = state_r;
    accept_s   = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (host.req) begin
          next_s   = ST_SETUP;
          accept_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        cnt_load_s = 1'b1;
        if (wr_r) begin
          next_s    = ST_WACC;
          cnt_val_s = LOAD_W;
        end else begin
          next_s    = ST_RACC;
          cnt_val_s = LOAD_R;
        end
      end
      ST_WACC, ST_RACC: begin
        if (cnt_zero_s) begin
          next_s = ST_DONE;
        end else begin
          next_s    = state_r;
          cnt_dec_s = 1'b1;
        end
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
    wr_next_s = accept_s ? host.wr : wr_r;
  end

  // State, request latches and registered outputs; outputs are decoded from the next state
  // so that each strobe flop already holds the value of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      wr_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      ceb_r     <= 1'b1;
      web_r     <= 1'b1;
      oeb_r     <= 1'b1;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      state_r <= next_s;
      if (accept_s) begin
        wr_r    <= host.wr;
        addr_r  <= host.addr;
        wdata_r <= host.wdata;
      end
      if (state_r == ST_RACC && cnt_zero_s) begin
        rdata_r <= ram_data;
      end
      ceb_r     <= !(next_s inside {ST_SETUP, ST_WACC, ST_RACC});
      web_r     <= (next_s != ST_WACC);
      oeb_r     <= (next_s != ST_RACC);
      data_oe_r <= wr_next_s && (next_s inside {ST_SETUP, ST_WACC, ST_DONE});
      busy_r    <= (next_s != ST_IDLE);
      ack_r     <= (next_s == ST_DONE);
    end
  end

  assign ram_addr   = addr_r;
  assign ram_data   = data_oe_r ? wdata_r : {DATA_W{1'bz}};
  assign ram_ceb    = ceb_r;
  assign ram_web    = web_r;
  assign ram_oeb    = oeb_r;
  assign host.busy  = busy_r;
  assign host.ack   = ack_r;
  assign host.rdata = rdata_r;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: table of write/read transactions against a behavioural SRAM,
// scoreboarded on ACK, plus busy-rejection, reset-abort and short read-strobe sequences.
module tb_ram_ctrl;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_ctrl_if host ();
  ram_ctrl_if h1 ();
  ram_ctrl_if h0 ();

  logic [3:0] ram_addr, a1, a0;
  wire  [7:0] ram_data, d1, d0;
  logic ram_ceb, ram_web, ram_oeb;
  logic ceb1, web1, oeb1, ceb0, web0, oeb0;

  ram_ctrl #(.WAIT_W(2), .WAIT_R(2)) dut (
    .clk(clk), .rst(rst), .host(host), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_oeb(ram_oeb));
  ram_ctrl #(.WAIT_W(2), .WAIT_R(1)) u_r1 (
    .clk(clk), .rst(rst), .host(h1), .ram_addr(a1), .ram_data(d1),
    .ram_ceb(ceb1), .ram_web(web1), .ram_oeb(oeb1));
  ram_ctrl #(.WAIT_W(2), .WAIT_R(0)) u_r0 (
    .clk(clk), .rst(rst), .host(h0), .ram_addr(a0), .ram_data(d0),
    .ram_ceb(ceb0), .ram_web(web0), .ram_oeb(oeb0));

  // Behavioural SRAM: writes while CEB and WEB are low, drives the bus while CEB and OEB are low.
  logic [7:0] mem [16];
  assign ram_data = (!ram_ceb && !ram_oeb) ? mem[ram_addr] : 8'hzz;
  always @(posedge clk) if (!ram_ceb && !ram_web) mem[ram_addr] <= ram_data;
  assign d1 = (!ceb1 && !oeb1) ? 8'h5A : 8'hzz;
  assign d0 = (!ceb0 && !oeb0) ? 8'hC3 : 8'hzz;

  int ilk_bad = 0;
  always @(negedge clk)
    ilk_bad <= ilk_bad + $countones({(!ram_web && !ram_oeb), (!ram_oeb && dut.data_oe_r),
                                     (!web1 && !oeb1), (!oeb1 && u_r1.data_oe_r),
                                     (!web0 && !oeb0), (!oeb0 && u_r0.data_oe_r)});

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       chk_data;
  } vec_t;

  vec_t       tbl [9];
  vec_t       sb [$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [3:0] last_addr = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit inject);
    int   ack_at, wlen, rlen;
    vec_t e;
    ack_at = -1; wlen = 0; rlen = 0;
    @(negedge clk);
    check("idle_busy", host.busy, 1'b0);
    check("idle_ack", host.ack, 1'b0);
    check("addr_hold", ram_addr, last_addr);
    host.req = 1'b1; host.wr = v.wr; host.addr = v.addr; host.wdata = v.wdata;
    sb.push_back(v);
    @(negedge clk);
    host.req = 1'b0;
    for (int i = 0; i < 20 && ack_at < 0; i++) begin
      if (i == 0) begin
        check("busy_setup", host.busy, 1'b1);
        check("addr_setup", ram_addr, v.addr);
        check("ceb_setup", ram_ceb, 1'b0);
      end
      if (!ram_web) wlen++;
      if (!ram_oeb) rlen++;
      if (host.ack) begin
        ack_at = i;
        e = sb.pop_front();
        if (e.chk_data) check("rdata", host.rdata, e.exp_rdata);
        if (e.wr) check("mem_write", mem[e.addr], e.wdata);
      end
      if (inject && i == 1) begin
        host.req = 1'b1; host.wr = 1'b1; host.addr = 4'd5; host.wdata = 8'hEE;
      end else if (inject && i == 2) begin
        host.req = 1'b0;
      end
      if (ack_at < 0) @(negedge clk);
    end
    if (ack_at < 0 && sb.size() > 0) void'(sb.pop_front());
    check("ack_latency", ack_at, 3);
    check("web_width", wlen, v.wr ? 2 : 0);
    check("oeb_width", rlen, v.wr ? 0 : 2);
    last_addr = v.addr;
  endtask

  initial begin
    int acks, l1, l0, k1, k0;
    vec_t v;
    tbl[0] = '{1'b1, 4'd3,  8'hA5, 8'h00, 1'b1};
    tbl[1] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b1};
    tbl[2] = '{1'b1, 4'd7,  8'h3C, 8'hA5, 1'b1};
    tbl[3] = '{1'b0, 4'd7,  8'h00, 8'h3C, 1'b1};
    tbl[4] = '{1'b1, 4'd15, 8'hFF, 8'h3C, 1'b1};
    tbl[5] = '{1'b0, 4'd15, 8'h00, 8'hFF, 1'b1};
    tbl[6] = '{1'b1, 4'd0,  8'h00, 8'hFF, 1'b1};
    tbl[7] = '{1'b0, 4'd0,  8'h00, 8'h00, 1'b1};
    tbl[8] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b1};

    rst = 1'b1;
    host.req = 1'b0; host.wr = 1'b0; host.addr = 4'd0; host.wdata = 8'h00;
    h1.req = 1'b0; h1.wr = 1'b0; h1.addr = 4'd0; h1.wdata = 8'h00;
    h0.req = 1'b0; h0.wr = 1'b0; h0.addr = 4'd0; h0.wdata = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ceb", ram_ceb, 1'b1);
    check("rst_web", ram_web, 1'b1);
    check("rst_oeb", ram_oeb, 1'b1);
    check("rst_busy", host.busy, 1'b0);
    check("rst_ack", host.ack, 1'b0);
    check("rst_addr", ram_addr, 4'd0);
    check("rst_rdata", host.rdata, 8'h00);
    check("rst_data_oe", dut.data_oe_r, 1'b0);
    check("rst_cnt", dut.u_wcnt.cnt_r, 4'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0);

    // Second request during WACC must be dropped; the next request 5 cycles on runs normally.
    v = '{1'b1, 4'd9, 8'h77, 8'hA5, 1'b1};
    run_txn(v, 1'b1);
    v = '{1'b0, 4'd9, 8'h00, 8'h77, 1'b1};
    run_txn(v, 1'b0);

    // Reset during the first write-strobe cycle.
    @(negedge clk);
    host.req = 1'b1; host.wr = 1'b1; host.addr = 4'd0; host.wdata = 8'h99;
    @(negedge clk);
    host.req = 1'b0;
    @(negedge clk);
    check("abort_web_active", ram_web, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ceb", ram_ceb, 1'b1);
    check("abort_web", ram_web, 1'b1);
    check("abort_busy", host.busy, 1'b0);
    check("abort_data_oe", dut.data_oe_r, 1'b0);
    check("abort_addr", ram_addr, 4'd0);
    check("abort_rdata", host.rdata, 8'h00);
    check("abort_cnt", dut.u_wcnt.cnt_r, 4'd0);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (host.ack) acks++;
      @(negedge clk);
    end
    check("abort_no_ack", acks, 0);
    last_addr = 4'd0;
    v = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0};
    run_txn(v, 1'b0);

    // WAIT_R=1 and WAIT_R=0 instances both give a single-cycle read strobe.
    @(negedge clk);
    h1.req = 1'b1; h1.addr = 4'd2;
    h0.req = 1'b1; h0.addr = 4'd2;
    @(negedge clk);
    h1.req = 1'b0; h0.req = 1'b0;
    l1 = 0; l0 = 0; k1 = -1; k0 = -1;
    for (int i = 0; i < 8; i++) begin
      if (!oeb1) l1++;
      if (!oeb0) l0++;
      if (h1.ack && k1 < 0) k1 = i;
      if (h0.ack && k0 < 0) k0 = i;
      @(negedge clk);
    end
    check("r1_oeb_width", l1, 1);
    check("r0_oeb_width", l0, 1);
    check("r1_ack_latency", k1, 2);
    check("r0_ack_latency", k0, 2);
    check("r1_rdata", h1.rdata, 8'h5A);
    check("r0_rdata", h0.rdata, 8'hC3);

    check("strobe_interlock", ilk_bad, 0);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
